// File: rtl/aes_pkg.sv
// Shared encodings for the moded block-cipher sequencer: mode codes, FSM states, default width.
package aes_pkg;

  localparam int BLK_W_DEF = 128;

  localparam logic [1:0] MODE_ECB = 2'd0;
  localparam logic [1:0] MODE_CBC = 2'd1;
  localparam logic [1:0] MODE_CTR = 2'd2;
  localparam logic [1:0] MODE_RSV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CORE = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/aes_moo_chain.sv
// Mode datapath: core input / result selection and the chaining register (IV, CBC feedback, CTR counter).
// Selection is combinational; xvar updates one edge after iv_load or upd, no backpressure of its own.
module aes_moo_chain
  import aes_pkg::*;
#(
  parameter int BLK_W = BLK_W_DEF,
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             enc,
  input  logic [BLK_W-1:0] blk_new,
  input  logic [BLK_W-1:0] blk,
  input  logic [BLK_W-1:0] core_out,
  input  logic             iv_load,
  input  logic [BLK_W-1:0] iv,
  input  logic             upd,
  output logic [BLK_W-1:0] sel_in,
  output logic             sel_enc,
  output logic [BLK_W-1:0] res,
  output logic [BLK_W-1:0] xvar
);

  // Incrementing the full word then masking gives a mod-2^CTR_W count that leaves upper bits alone.
  localparam logic [BLK_W-1:0] CTR_MASK = {BLK_W{1'b1}} >> (BLK_W - CTR_W);

  logic [BLK_W-1:0] xvar_ctr;

  assign xvar_ctr = (xvar & ~CTR_MASK) | ((xvar + BLK_W'(1)) & CTR_MASK);

  always_comb begin
    sel_in  = blk_new;
    sel_enc = enc;
    case (mode)
      MODE_CBC: if (enc) sel_in = blk_new ^ xvar;
      MODE_CTR: begin
        sel_in  = xvar;
        sel_enc = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    res = core_out;
    case (mode)
      MODE_CBC: if (!enc) res = core_out ^ xvar;
      MODE_CTR: res = blk ^ core_out;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xvar <= '0;
    end else if (iv_load) begin
      xvar <= iv;
    end else if (upd) begin
      case (mode)
        MODE_CBC: xvar <= enc ? core_out : blk;
        MODE_CTR: xvar <= xvar_ctr;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/aes_moo_stream.sv
// ECB/CBC/CTR sequencer around an external block cipher; one block in flight, out_valid L+2 cycles after accept.
// in_ready only in LOAD; OUT holds its result until out_ready, so a stalled sink stalls the input side.
module aes_moo_stream
  import aes_pkg::*;
#(
  parameter int BLK_W = BLK_W_DEF,
  parameter int CTR_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_enc,
  input  logic [BLK_W-1:0] cfg_iv,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             cfg_err,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             core_start,
  output logic             core_enc,
  output logic [BLK_W-1:0] core_in,
  input  logic [BLK_W-1:0] core_out,
  input  logic             core_done
);

  state_t           state, state_nxt;
  logic [1:0]       mode_q;
  logic             enc_q;
  logic [BLK_W-1:0] blk_in;
  logic             last_q;
  logic             accept, done_ev, xfer, cfg_ok, cfg_bad;
  logic [BLK_W-1:0] sel_in, res, xvar;
  logic             sel_enc;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_ev   = 1'b0;
    xfer      = 1'b0;
    cfg_ok    = 1'b0;
    cfg_bad   = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cfg_start) begin
          if (cfg_mode == MODE_RSV) begin
            cfg_bad = 1'b1;
          end else begin
            cfg_ok    = 1'b1;
            state_nxt = ST_LOAD;
          end
        end
        ST_LOAD: if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_CORE;
        end
        ST_CORE: if (core_done) begin
          done_ev   = 1'b1;
          state_nxt = ST_OUT;
        end
        ST_OUT: if (out_ready) begin
          xfer      = 1'b1;
          state_nxt = last_q ? ST_IDLE : ST_LOAD;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // An abort in LOAD must not look like a completed handshake to the source.
  assign in_ready = (state == ST_LOAD) && !abort;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_ECB;
      enc_q      <= 1'b0;
      blk_in     <= '0;
      last_q     <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      cfg_err    <= 1'b0;
      blk_cnt    <= '0;
      core_start <= 1'b0;
      core_enc   <= 1'b0;
      core_in    <= '0;
    end else begin
      core_start <= accept;
      if (cfg_ok) begin
        mode_q  <= cfg_mode;
        enc_q   <= cfg_enc;
        blk_cnt <= '0;
        cfg_err <= 1'b0;
      end
      if (cfg_bad) cfg_err <= 1'b1;
      if (accept) begin
        blk_in   <= in_data;
        last_q   <= in_last;
        core_in  <= sel_in;
        core_enc <= sel_enc;
      end
      if (done_ev) begin
        out_data  <= res;
        out_valid <= 1'b1;
        out_last  <= last_q;
      end
      if (xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        if (blk_cnt != {CNT_W{1'b1}}) blk_cnt <= blk_cnt + 1'b1;
      end
      if (abort) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  aes_moo_chain #(
    .BLK_W (BLK_W),
    .CTR_W (CTR_W)
  ) u_chain (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode_q),
    .enc      (enc_q),
    .blk_new  (in_data),
    .blk      (blk_in),
    .core_out (core_out),
    .iv_load  (cfg_ok),
    .iv       (cfg_iv),
    .upd      (done_ev),
    .sel_in   (sel_in),
    .sel_enc  (sel_enc),
    .res      (res),
    .xvar     (xvar)
  );

endmodule

// File: tb/tb_aes_moo_stream.sv
// Directed bench for aes_moo_stream against a table-driven cipher core loaded with SP800-38A AES-256 vectors.
module tb_aes_moo_stream;
  import aes_pkg::*;

  localparam int BW = 128;
  localparam int L  = 14;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cfg_start = 1'b0, cfg_enc = 1'b0, abort = 1'b0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [BW-1:0] cfg_iv = '0, in_data = '0;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, out_last, busy, cfg_err, core_start, core_enc, core_done;
  logic [BW-1:0] out_data, core_in, core_out;
  logic [15:0]   blk_cnt;

  int n_chk = 0, n_err = 0, cyc = 0;

  logic [BW-1:0] tab_in [9];
  logic [BW-1:0] tab_out[9];
  logic [BW-1:0] cin_log[$];
  logic [BW-1:0] c_in = '0;
  logic          c_enc = 1'b0;
  int            c_cnt;
  logic [BW-1:0] fake = 128'h5a5a_a5a5_3c3c_c3c3_0ff0_f00f_1234_8765;

  logic [BW-1:0] iv_cbc = 128'h000102030405060708090a0b0c0d0e0f;
  logic [BW-1:0] ctr0   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  logic [BW-1:0] ivw    = 128'h0123456789abcdef01234567ffffffff;
  logic [BW-1:0] pt[4], ct[4], ecb[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_moo_stream dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_enc(cfg_enc),
    .cfg_iv(cfg_iv), .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .cfg_err(cfg_err), .blk_cnt(blk_cnt),
    .core_start(core_start), .core_enc(core_enc), .core_in(core_in), .core_out(core_out),
    .core_done(core_done)
  );

  // Behavioural core: fixed latency L from core_start, forward/inverse by table lookup.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_cnt <= 0;
    end else if (core_start) begin
      c_cnt <= L;
      c_in  <= core_in;
      c_enc <= core_enc;
      cin_log.push_back(core_in);
    end else if (c_cnt != 0) begin
      c_cnt <= c_cnt - 1;
    end
  end

  function automatic logic [BW-1:0] cipher(input logic [BW-1:0] x, input logic e);
    for (int i = 0; i < 9; i++) begin
      if (e && tab_in[i] == x) return tab_out[i];
      if (!e && tab_out[i] == x) return tab_in[i];
    end
    return x ^ fake;
  endfunction

  assign core_done = (c_cnt == 1);
  assign core_out  = cipher(c_in, c_enc);

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_sess(input logic [1:0] m, input logic e, input logic [BW-1:0] iv);
    @(negedge clk);
    cfg_start = 1'b1; cfg_mode = m; cfg_enc = e; cfg_iv = iv;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_blk(input logic [BW-1:0] d, input logic l, output int acc);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) check_eq("in_ready_timeout", 0, 1);
    acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [BW-1:0] d, output logic l, output int oc);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    if (!out_valid) check_eq("out_valid_timeout", 0, 1);
    d = out_data; l = out_last; oc = cyc;
  endtask

  task automatic take_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] d, tmp;
    logic          l;
    int            acc, oc;

    pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;  pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;  pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    ct[0] = 128'hf58c4c04d6e5f1ba779eabfb5f7bfbd6;  ct[1] = 128'h9cfc4e967edb808d679f777bc6702c7d;
    ct[2] = 128'h39f23369a9d9bacfa530e26304231461;  ct[3] = 128'hb2eb05e2c39be9fcda6c19078c6a9d64;
    ecb[0] = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8; ecb[1] = 128'h591ccb10d410ed26dc5ba74a31362870;
    ecb[2] = 128'hb6ed21b99ca6f4f9f153e7b1beafed1d; ecb[3] = 128'h23304b7a39f9f3ff067d8d8f9e24ecc7;
    for (int i = 0; i < 4; i++) begin
      tab_in[i]      = pt[i];
      tab_out[i]     = ecb[i];
      tab_in[4 + i]  = pt[i] ^ ((i == 0) ? iv_cbc : ct[i - 1]);
      tab_out[4 + i] = ct[i];
    end
    tab_in[8]  = ctr0;
    tab_out[8] = pt[0] ^ 128'h601ec313775789a5b7a7f504bbf3d228;

    // Reset state
    #12;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cfg_err", cfg_err, 0);
    check_eq("rst_core_in", core_in, 0);
    check_eq("rst_xvar", dut.u_chain.xvar, 0);
    @(negedge clk); rst_n = 1'b1;

    // CBC encrypt, four-block stream
    start_sess(MODE_CBC, 1'b1, iv_cbc);
    check_eq("cbc_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      send_blk(pt[i], i == 3, acc);
      wait_out(d, l, oc);
      if (i == 0) check_eq("cbc_latency", oc - acc, L + 2);
      check_eq("cbc_enc_data", d, ct[i]);
      check_eq("cbc_enc_last", l, (i == 3));
      take_out;
    end
    check_eq("cbc_blk_cnt", blk_cnt, 4);
    check_eq("cbc_idle", busy, 0);

    // CBC decrypt of the same ciphertexts
    start_sess(MODE_CBC, 1'b0, iv_cbc);
    for (int i = 0; i < 4; i++) begin
      send_blk(ct[i], i == 3, acc);
      wait_out(d, l, oc);
      check_eq("cbc_dec_data", d, pt[i]);
      take_out;
    end
    check_eq("cbc_dec_xvar", dut.u_chain.xvar, ct[3]);

    // CTR block 1
    start_sess(MODE_CTR, 1'b1, ctr0);
    send_blk(pt[0], 1'b1, acc);
    wait_out(d, l, oc);
    check_eq("ctr_data", d, 128'h601ec313775789a5b7a7f504bbf3d228);
    check_eq("ctr_core_enc", core_enc, 1);
    take_out;

    // CTR counter wrap, run in decrypt direction
    cin_log.delete();
    start_sess(MODE_CTR, 1'b0, ivw);
    send_blk(128'h11112222333344445555666677778888, 1'b0, acc);
    wait_out(d, l, oc);
    check_eq("wrap_blk0", d, 128'h11112222333344445555666677778888 ^ ivw ^ fake);
    take_out;
    send_blk(128'hdeadbeef00000000cafef00d12345678, 1'b1, acc);
    wait_out(d, l, oc);
    tmp = {ivw[127:32], 32'h0};
    check_eq("wrap_blk1", d, 128'hdeadbeef00000000cafef00d12345678 ^ tmp ^ fake);
    check_eq("wrap_log_size", cin_log.size(), 2);
    if (cin_log.size() >= 2) begin
      tmp = cin_log[1];
      check_eq("wrap_core_in_lo", tmp[31:0], 0);
      check_eq("wrap_core_in_hi", tmp[127:32], ivw[127:32]);
    end
    take_out;
    tmp = {ivw[127:32], 32'h1};
    check_eq("wrap_xvar", dut.u_chain.xvar, tmp);

    // ECB with the sink stalled for 20 cycles
    start_sess(MODE_ECB, 1'b1, '0);
    send_blk(pt[0], 1'b1, acc);
    wait_out(d, l, oc);
    check_eq("ecb_data", d, ecb[0]);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq("ecb_hold_data", out_data, ecb[0]);
      check_eq("ecb_hold_in_ready", in_ready, 0);
    end
    take_out;
    check_eq("ecb_blk_cnt", blk_cnt, 1);

    // Reserved mode
    start_sess(MODE_RSV, 1'b1, '0);
    @(negedge clk);
    check_eq("rsv_cfg_err", cfg_err, 1);
    check_eq("rsv_busy", busy, 0);

    // Abort during CORE; the stale core_done must be ignored
    start_sess(MODE_ECB, 1'b1, 128'h0badf00d);
    check_eq("cfg_err_clear", cfg_err, 0);
    send_blk(pt[1], 1'b1, acc);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_eq("abort_idle", busy, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq("abort_no_out", out_valid, 0);
    end
    check_eq("abort_xvar", dut.u_chain.xvar, 128'h0badf00d);
    check_eq("abort_blk_cnt", blk_cnt, 0);

    // Async reset while holding a result in OUT
    start_sess(MODE_ECB, 1'b1, '0);
    send_blk(pt[2], 1'b1, acc);
    wait_out(d, l, oc);
    check_eq("pre_rst_data", d, ecb[2]);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_out_data", out_data, 0);
    check_eq("arst_out_last", out_last, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_core_in", core_in, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
